// File: rtl/operand_entry.sv
// Calculator input stage: synchronised digit sliders with hold-to-repeat feed a
// 4-digit BCD edit buffer, and enter sequences operand A -> operand B -> result.
module operand_entry #(
  parameter int SLIDER_OVERFLOW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sld_1,
  input  logic        sld_2,
  input  logic        sld_3,
  input  logic        sld_4,
  input  logic        sld_arith,
  input  logic        ent_pulse,
  input  logic        clr_pulse,
  output logic [15:0] edit_digits,
  output logic [15:0] operand_a,
  output logic [15:0] operand_b,
  output logic        op_sub,
  output logic        operands_valid,
  output logic [1:0]  entry_state
);

  localparam int CW = (SLIDER_OVERFLOW < 1) ? 1 : $clog2(SLIDER_OVERFLOW + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SLIDER_OVERFLOW);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    RESULT  = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      sld_raw;
  logic [3:0]      s1, s2, s3;
  logic            ar_s1, ar_s2;
  logic            ent_q;
  logic            ent_fire;
  logic [3:0][3:0] digits;
  logic [CW-1:0]   cnt [4];
  logic [3:0]      rise, hold, at_max;

  assign sld_raw     = {sld_4, sld_3, sld_2, sld_1};
  assign edit_digits = digits;
  assign entry_state = state;
  // A held enter only advances once: act on its rising edge.
  assign ent_fire    = ent_pulse & ~ent_q;

  always_comb begin
    at_max = '0;
    rise   = s2 & ~s3;
    hold   = s2 & s3;
    for (int unsigned i = 0; i < 4; i++) begin
      at_max[i] = (cnt[i] == CNT_MAX);
    end
  end

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ENTER_A;
      s1             <= '0;
      s2             <= '0;
      s3             <= '0;
      ar_s1          <= 1'b0;
      ar_s2          <= 1'b0;
      ent_q          <= 1'b0;
      digits         <= '0;
      operand_a      <= '0;
      operand_b      <= '0;
      op_sub         <= 1'b0;
      operands_valid <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1             <= sld_raw;
      s2             <= s1;
      s3             <= s2;
      ar_s1          <= sld_arith;
      ar_s2          <= ar_s1;
      ent_q          <= ent_pulse;
      operands_valid <= 1'b0;

      if (clr_pulse) begin
        state     <= ENTER_A;
        digits    <= '0;
        operand_a <= '0;
        operand_b <= '0;
        op_sub    <= 1'b0;
        for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
      end else if (ent_fire) begin
        // Any slider increment in this cycle is dropped along with its count.
        for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        case (state)
          ENTER_A: begin
            operand_a <= digits;
            digits    <= '0;
            state     <= ENTER_B;
          end
          ENTER_B: begin
            operand_b      <= digits;
            op_sub         <= ar_s2;
            operands_valid <= 1'b1;
            digits         <= '0;
            state          <= RESULT;
          end
          default: state <= ENTER_A;
        endcase
      end else if (state == RESULT) begin
        for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (rise[i]) begin
            digits[i] <= bcd_inc(digits[i]);
            cnt[i]    <= '0;
          end else if (hold[i]) begin
            if (at_max[i]) begin
              digits[i] <= bcd_inc(digits[i]);
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end else begin
            cnt[i] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with SLIDER_OVERFLOW = 3; inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_operand_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sld;
  logic        sld_arith;
  logic        ent_pulse;
  logic        clr_pulse;
  logic [15:0] edit_digits;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        op_sub;
  logic        operands_valid;
  logic [1:0]  entry_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_entry #(.SLIDER_OVERFLOW(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .sld_1          (sld[0]),
    .sld_2          (sld[1]),
    .sld_3          (sld[2]),
    .sld_4          (sld[3]),
    .sld_arith      (sld_arith),
    .ent_pulse      (ent_pulse),
    .clr_pulse      (clr_pulse),
    .edit_digits    (edit_digits),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .op_sub         (op_sub),
    .operands_valid (operands_valid),
    .entry_state    (entry_state)
  );

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One sampled-high clock on a slider gives exactly one increment.
  task automatic bump(input int idx, input int count);
    for (int k = 0; k < count; k++) begin
      sld[idx] = 1'b1;
      tick();
      sld[idx] = 1'b0;
      tick(2);
    end
    tick(3);
  endtask

  task automatic do_clr();
    clr_pulse = 1'b1;
    tick();
    clr_pulse = 1'b0;
  endtask

  task automatic do_ent();
    ent_pulse = 1'b1;
    tick();
    ent_pulse = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    n_checks++;
    if (edit_digits !== 16'h0000) begin n_fail++; $display("FAIL reset_edit got %h exp 0000", edit_digits); end
    n_checks++;
    if ({operand_a, operand_b} !== 32'h0) begin n_fail++; $display("FAIL reset_ops got %h/%h exp 0/0", operand_a, operand_b); end
    n_checks++;
    if ({op_sub, operands_valid, entry_state} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl got %b exp 0000", {op_sub, operands_valid, entry_state}); end
  endtask

  task automatic test_hold_repeat();
    sld[0] = 1'b1;
    tick(2);
    n_checks++;
    if (edit_digits !== 16'h0000) begin n_fail++; $display("FAIL hold_latency2 got %h exp 0000", edit_digits); end
    tick();
    n_checks++;
    if (edit_digits !== 16'h0001) begin n_fail++; $display("FAIL hold_first_inc got %h exp 0001", edit_digits); end
    tick(7);
    sld[0] = 1'b0;
    tick(4);
    n_checks++;
    if (edit_digits !== 16'h0003) begin n_fail++; $display("FAIL hold_10clk got %h exp 0003", edit_digits); end
  endtask

  task automatic test_wrap();
    do_clr();
    n_checks++;
    if (edit_digits !== 16'h0000) begin n_fail++; $display("FAIL clr_edit got %h exp 0000", edit_digits); end
    sld[1] = 1'b1;
    tick(45);
    sld[1] = 1'b0;
    tick(4);
    n_checks++;
    if (edit_digits !== 16'h0020) begin n_fail++; $display("FAIL wrap_45clk got %h exp 0020", edit_digits); end
  endtask

  task automatic test_multi();
    do_clr();
    sld[1:0] = 2'b11;
    tick(5);
    sld[1:0] = 2'b00;
    tick(4);
    n_checks++;
    if (edit_digits !== 16'h0022) begin n_fail++; $display("FAIL multi_hold got %h exp 0022", edit_digits); end
    do_clr();
  endtask

  task automatic test_sequence();
    bump(3, 1);
    bump(2, 2);
    bump(1, 3);
    bump(0, 4);
    n_checks++;
    if (edit_digits !== 16'h1234) begin n_fail++; $display("FAIL seq_edit_a got %h exp 1234", edit_digits); end
    do_ent();
    n_checks++;
    if ({entry_state, edit_digits, operand_a} !== {2'd1, 16'h0000, 16'h1234}) begin
      n_fail++; $display("FAIL seq_latch_a got st=%0d edit=%h a=%h exp st=1 edit=0000 a=1234", entry_state, edit_digits, operand_a);
    end
    sld_arith = 1'b1;
    bump(2, 5);
    bump(1, 6);
    bump(0, 7);
    n_checks++;
    if (operands_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_early got %b exp 0", operands_valid); end
    do_ent();
    n_checks++;
    if ({operands_valid, entry_state, op_sub} !== {1'b1, 2'd2, 1'b1}) begin
      n_fail++; $display("FAIL seq_latch_b got v=%b st=%0d sub=%b exp v=1 st=2 sub=1", operands_valid, entry_state, op_sub);
    end
    n_checks++;
    if ({operand_a, operand_b, edit_digits} !== {16'h1234, 16'h0567, 16'h0000}) begin
      n_fail++; $display("FAIL seq_operands got a=%h b=%h edit=%h exp 1234 0567 0000", operand_a, operand_b, edit_digits);
    end
    tick();
    n_checks++;
    if (operands_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_width got %b exp 0", operands_valid); end
  endtask

  task automatic test_result_state();
    logic seen_valid = 1'b0;
    sld[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen_valid |= operands_valid;
    end
    sld[3] = 1'b0;
    tick(4);
    n_checks++;
    if (edit_digits !== 16'h0000) begin n_fail++; $display("FAIL result_ignore got %h exp 0000", edit_digits); end
    n_checks++;
    if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL result_refire got %b exp 0", seen_valid); end
    // Wide enter must advance only once.
    ent_pulse = 1'b1;
    tick(3);
    ent_pulse = 1'b0;
    tick();
    n_checks++;
    if (entry_state !== 2'd0) begin n_fail++; $display("FAIL result_exit got %0d exp 0", entry_state); end
    n_checks++;
    if ({operand_a, operand_b, op_sub} !== {16'h1234, 16'h0567, 1'b1}) begin
      n_fail++; $display("FAIL result_keep got a=%h b=%h sub=%b exp 1234 0567 1", operand_a, operand_b, op_sub);
    end
  endtask

  task automatic test_clr_ent_same();
    bump(0, 1);
    do_ent();
    bump(1, 4);
    bump(0, 2);
    n_checks++;
    if ({entry_state, edit_digits, operand_a} !== {2'd1, 16'h0042, 16'h0001}) begin
      n_fail++; $display("FAIL clrent_setup got st=%0d edit=%h a=%h exp 1 0042 0001", entry_state, edit_digits, operand_a);
    end
    clr_pulse = 1'b1;
    ent_pulse = 1'b1;
    tick();
    clr_pulse = 1'b0;
    ent_pulse = 1'b0;
    n_checks++;
    if ({edit_digits, operand_a, operand_b} !== 48'h0) begin
      n_fail++; $display("FAIL clrent_data got edit=%h a=%h b=%h exp 0 0 0", edit_digits, operand_a, operand_b);
    end
    n_checks++;
    if ({op_sub, operands_valid, entry_state} !== 4'b0000) begin
      n_fail++; $display("FAIL clrent_ctl got %b exp 0000", {op_sub, operands_valid, entry_state});
    end
    tick();
    n_checks++;
    if (operands_valid !== 1'b0) begin n_fail++; $display("FAIL clrent_valid_late got %b exp 0", operands_valid); end
    sld_arith = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    bump(0, 1);
    do_ent();
    sld[2] = 1'b1;
    tick(6);
    n_checks++;
    if ({entry_state, edit_digits, operand_a} !== {2'd1, 16'h0100, 16'h0001}) begin
      n_fail++; $display("FAIL rsthold_setup got st=%0d edit=%h a=%h exp 1 0100 0001", entry_state, edit_digits, operand_a);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({edit_digits, operand_a, entry_state} !== 34'h0) begin
      n_fail++; $display("FAIL rsthold_clear got edit=%h a=%h st=%0d exp 0 0 0", edit_digits, operand_a, entry_state);
    end
    tick(2);
    n_checks++;
    if (edit_digits !== 16'h0000) begin n_fail++; $display("FAIL rsthold_latency got %h exp 0000", edit_digits); end
    tick();
    n_checks++;
    if (edit_digits !== 16'h0100) begin n_fail++; $display("FAIL rsthold_rise got %h exp 0100", edit_digits); end
    sld[2] = 1'b0;
    tick(4);
  endtask

  initial begin
    reset     = 1'b1;
    sld       = '0;
    sld_arith = 1'b0;
    ent_pulse = 1'b0;
    clr_pulse = 1'b0;
    test_reset();
    test_hold_repeat();
    test_wrap();
    test_multi();
    test_sequence();
    test_result_state();
    test_clr_ent_same();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
